// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//   Sequences one command at a time through an external combinational or
//   pipelined 4-bit ALU. A command is latched onto the ALU operand outputs,
//   the ALU result is sampled ALU_LAT edges later, optionally written back into
//   a 4-bit accumulator, and then presented downstream until it is taken.
//
// Handshakes (both sides use the same rule): a transfer happens on a rising
// edge where valid and ready are both high. cmd_ready depends only on the FSM
// state. res_valid, once high, stays high with res_f/res_abflag stable until
// the edge on which res_ready is also high.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_sel/m/cn/src/a/b  ALU function, mode, carry-in (active low),
//                         A source (0 = accumulator, 1 = cmd_a), operands
//   cmd_wb                write the result into the accumulator
//   acc_clr               synchronous accumulator clear, wins over writeback
//   alu_sel/a/b/m/cn      registered operands/controls to the ALU
//   alu_f, alu_abflag     ALU result and all-ones flag
//   res_valid/res_ready   result handshake
//   res_f, res_abflag     captured result and flag
//   acc                   accumulator value
//   op_count              completed-result count (wraps)
//   dbg_state             current FSM state
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_sel,
    input  logic       cmd_m,
    input  logic       cmd_cn,
    input  logic       cmd_src,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic       cmd_wb,
    input  logic       acc_clr,
    output logic [3:0] alu_sel,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_m,
    output logic       alu_cn,
    input  logic [3:0] alu_f,
    input  logic       alu_abflag,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_f,
    output logic       res_abflag,
    output logic [3:0] acc,
    output logic [7:0] op_count,
    output logic [1:0] dbg_state
);

    if (ALU_LAT < 1 || ALU_LAT > 4) begin : g_bad_lat
        $error("alu_op_sequencer: ALU_LAT must be in 1..4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       w_launch;
    logic       w_capture;
    logic       w_done;

    logic [1:0] r_cnt;
    logic       r_wb;
    logic [3:0] r_alu_sel;
    logic [3:0] r_alu_a;
    logic [3:0] r_alu_b;
    logic       r_alu_m;
    logic       r_alu_cn;
    logic       r_res_valid;
    logic [3:0] r_res_f;
    logic       r_res_abflag;
    logic [3:0] r_acc;
    logic [7:0] r_op_count;

    // Next-state and per-edge strobes.
    always_comb begin
        w_next_state = r_state;
        w_launch     = 1'b0;
        w_capture    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_launch     = 1'b1;
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                // Counter holds the number of further edges to wait before
                // the ALU output is sampled.
                if (r_cnt == 2'd0) begin
                    w_capture    = 1'b1;
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (res_ready) begin
                    w_done       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 2'd0;
            r_wb         <= 1'b0;
            r_alu_sel    <= 4'd0;
            r_alu_a      <= 4'd0;
            r_alu_b      <= 4'd0;
            r_alu_m      <= 1'b0;
            r_alu_cn     <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_f      <= 4'd0;
            r_res_abflag <= 1'b0;
            r_acc        <= 4'd0;
            r_op_count   <= 8'd0;
        end else begin
            r_state <= w_next_state;

            if (w_launch) begin
                r_alu_sel <= cmd_sel;
                r_alu_m   <= cmd_m;
                r_alu_cn  <= cmd_cn;
                r_alu_b   <= cmd_b;
                // Accumulator value as it stands before this edge.
                r_alu_a   <= cmd_src ? cmd_a : r_acc;
                r_wb      <= cmd_wb;
                r_cnt     <= 2'(ALU_LAT - 1);
            end else if (r_state == S_EXEC && r_cnt != 2'd0) begin
                r_cnt <= r_cnt - 2'd1;
            end

            if (w_capture) begin
                r_res_f      <= alu_f;
                r_res_abflag <= alu_abflag;
                r_res_valid  <= 1'b1;
            end else if (w_done) begin
                r_res_valid  <= 1'b0;
                r_op_count   <= r_op_count + 8'd1;
            end

            if (acc_clr) begin
                r_acc <= 4'd0;
            end else if (w_capture && r_wb) begin
                r_acc <= alu_f;
            end
        end
    end

    assign cmd_ready  = (r_state == S_IDLE);
    assign dbg_state  = r_state;
    assign alu_sel    = r_alu_sel;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_m      = r_alu_m;
    assign alu_cn     = r_alu_cn;
    assign res_valid  = r_res_valid;
    assign res_f      = r_res_f;
    assign res_abflag = r_res_abflag;
    assign acc        = r_acc;
    assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
//   Two sequencers (ALU_LAT = 1 and ALU_LAT = 3) share the command fields and
//   run each command in lock-step. Each has a stand-in ALU. The reference model
//   tracks accumulator and op count per instance and derives, for every cycle
//   after the accept edge, which outputs must be seen.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] cmd_sel, cmd_a, cmd_b;
    logic       cmd_m, cmd_cn, cmd_src, cmd_wb;

    logic       cmd_valid[2], cmd_ready[2], acc_clr[2];
    logic       res_valid[2], res_ready[2], res_abflag[2];
    logic       alu_m[2], alu_cn[2], alu_abflag[2];
    logic [3:0] alu_sel[2], alu_a[2], alu_b[2], alu_f[2], res_f[2], acc[2];
    logic [7:0] op_count[2];
    logic [1:0] dbg_state[2];

    int n_total = 0;
    int n_bad   = 0;

    logic [3:0] acc_m[2];
    logic [7:0] cnt_m[2];

    // Stand-in ALU. In logic mode select 14 adds; other logic selects mix
    // the operands with the select; arithmetic mode adds with carry and select.
    function automatic logic [3:0] alu_fn(input logic [3:0] sel, input logic m,
                                          input logic cn, input logic [3:0] a,
                                          input logic [3:0] b);
        logic [3:0] r;
        if (m) begin
            if (sel == 4'd14) r = a + b;
            else              r = a ^ b ^ sel;
        end else begin
            r = a + b + {3'b000, ~cn} + sel - 4'd1;
        end
        return r;
    endfunction

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_op_sequencer #(.ALU_LAT(g == 0 ? 1 : 3)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .cmd_valid  (cmd_valid[g]),
            .cmd_ready  (cmd_ready[g]),
            .cmd_sel    (cmd_sel),
            .cmd_m      (cmd_m),
            .cmd_cn     (cmd_cn),
            .cmd_src    (cmd_src),
            .cmd_a      (cmd_a),
            .cmd_b      (cmd_b),
            .cmd_wb     (cmd_wb),
            .acc_clr    (acc_clr[g]),
            .alu_sel    (alu_sel[g]),
            .alu_a      (alu_a[g]),
            .alu_b      (alu_b[g]),
            .alu_m      (alu_m[g]),
            .alu_cn     (alu_cn[g]),
            .alu_f      (alu_f[g]),
            .alu_abflag (alu_abflag[g]),
            .res_valid  (res_valid[g]),
            .res_ready  (res_ready[g]),
            .res_f      (res_f[g]),
            .res_abflag (res_abflag[g]),
            .acc        (acc[g]),
            .op_count   (op_count[g]),
            .dbg_state  (dbg_state[g])
        );
        assign alu_f[g]      = alu_fn(alu_sel[g], alu_m[g], alu_cn[g], alu_a[g], alu_b[g]);
        assign alu_abflag[g] = (alu_f[g] == 4'hF);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("%s_acc%0d", tag, g),       32'(acc[g]), 0);
            check($sformatf("%s_res_f%0d", tag, g),     32'(res_f[g]), 0);
            check($sformatf("%s_abflag%0d", tag, g),    32'(res_abflag[g]), 0);
            check($sformatf("%s_count%0d", tag, g),     32'(op_count[g]), 0);
            check($sformatf("%s_alu%0d", tag, g),
                  32'({alu_sel[g], alu_a[g], alu_b[g], alu_m[g], alu_cn[g]}), 0);
            check($sformatf("%s_res_valid%0d", tag, g), 32'(res_valid[g]), 0);
            check($sformatf("%s_cmd_ready%0d", tag, g), 32'(cmd_ready[g]), 1);
        end
    endtask

    // One command through both instances. hold = extra RESP cycles with
    // res_ready low; clr = acc_clr on the capture edge; keep_valid = cmd_valid
    // of the ALU_LAT=3 instance stays high throughout EXEC.
    task automatic run_op(input logic src, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] sel, input logic m, input logic cn,
                          input logic wb, input int hold, input bit clr,
                          input bit keep_valid);
        logic [3:0] ea[2], ef[2], acc_new[2];
        int         h[2];
        for (int g = 0; g < 2; g++) begin
            ea[g]      = src ? a : acc_m[g];
            ef[g]      = alu_fn(sel, m, cn, ea[g], b);
            acc_new[g] = clr ? 4'd0 : (wb ? ef[g] : acc_m[g]);
            h[g]       = lat_of(g) + hold + 1;
        end
        @(negedge clk);
        cmd_src = src; cmd_a = a; cmd_b = b; cmd_sel = sel;
        cmd_m = m; cmd_cn = cn; cmd_wb = wb;
        for (int g = 0; g < 2; g++) begin
            check($sformatf("ready_before%0d", g), 32'(cmd_ready[g]), 1);
            cmd_valid[g] = 1'b1;
        end
        @(posedge clk);
        for (int c = 0; c <= h[1]; c++) begin
            @(negedge clk);
            if (c == 0) begin
                // Fields of a command not being accepted must be ignored.
                cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_sel = 4'($urandom);
                cmd_m = 1'($urandom); cmd_cn = 1'($urandom);
                cmd_src = 1'($urandom); cmd_wb = 1'($urandom);
            end
            for (int g = 0; g < 2; g++) begin
                int  l;
                bit  in_resp;
                l = lat_of(g);
                in_resp = (c >= l) && (c < h[g]);
                if (c <= h[g]) begin
                    check($sformatf("alu_ops%0d_c%0d", g, c),
                          32'({alu_sel[g], alu_a[g], alu_b[g], alu_m[g], alu_cn[g]}),
                          32'({sel, ea[g], b, m, cn}));
                    check($sformatf("acc%0d_c%0d", g, c), 32'(acc[g]),
                          32'((c < l) ? acc_m[g] : acc_new[g]));
                    check($sformatf("res_valid%0d_c%0d", g, c), 32'(res_valid[g]), 32'(in_resp));
                    check($sformatf("cmd_ready%0d_c%0d", g, c), 32'(cmd_ready[g]), 32'(c == h[g]));
                    check($sformatf("op_count%0d_c%0d", g, c), 32'(op_count[g]),
                          32'((c < h[g]) ? cnt_m[g] : cnt_m[g] + 8'd1));
                    if (in_resp) begin
                        check($sformatf("res_f%0d_c%0d", g, c), 32'(res_f[g]), 32'(ef[g]));
                        check($sformatf("res_ab%0d_c%0d", g, c), 32'(res_abflag[g]),
                              32'(ef[g] == 4'hF));
                    end
                end
                cmd_valid[g] = (keep_valid && g == 1 && c < l) ? 1'b1 : 1'b0;
                acc_clr[g]   = clr && (c == l - 1);
                res_ready[g] = (c == h[g] - 1);
            end
            if (c < h[1]) @(posedge clk);
        end
        for (int g = 0; g < 2; g++) begin
            acc_m[g] = acc_new[g];
            cnt_m[g] = cnt_m[g] + 8'd1;
        end
    endtask

    initial begin
        rst_n = 1'b1;
        cmd_sel = 0; cmd_a = 0; cmd_b = 0; cmd_m = 0; cmd_cn = 0; cmd_src = 0; cmd_wb = 0;
        for (int g = 0; g < 2; g++) begin
            cmd_valid[g] = 0; acc_clr[g] = 0; res_ready[g] = 0;
            acc_m[g] = 0; cnt_m[g] = 0;
        end
        #3 rst_n = 1'b0;
        #1 check_reset_vals("reset");
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b1;

        // Directed: worked example sequence.
        run_op(1, 4'd5, 4'd3, 4'd14, 1, 1, 1, 0, 0, 0);   // 8
        run_op(0, 4'd0, 4'd7, 4'd14, 1, 1, 1, 0, 0, 0);   // 15, flag
        run_op(0, 4'd0, 4'd1, 4'd1,  0, 1, 1, 0, 0, 0);   // wraps to 0
        // Result held while downstream stalls.
        run_op(1, 4'd6, 4'd4, 4'd3,  1, 0, 1, 5, 0, 0);
        // cmd_valid kept high during EXEC must not start a second op.
        run_op(1, 4'd2, 4'd9, 4'd7,  0, 0, 0, 1, 0, 1);
        // Clear on the capture edge beats a writeback of 9.
        run_op(1, 4'd4, 4'd5, 4'd14, 1, 1, 1, 0, 1, 0);

        // Random commands.
        for (int i = 0; i < 40; i++) begin
            run_op(1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                   1'($urandom));
        end

        // Reset while the ALU_LAT=3 instance is mid-EXEC.
        @(negedge clk);
        cmd_src = 1; cmd_a = 4'd9; cmd_b = 4'd2; cmd_sel = 4'd14;
        cmd_m = 1; cmd_cn = 1; cmd_wb = 1;
        cmd_valid[0] = 1; cmd_valid[1] = 1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid[0] = 0; cmd_valid[1] = 0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("abort");
        for (int g = 0; g < 2; g++) begin
            acc_m[g] = 0; cnt_m[g] = 0;
        end
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b1;
        // First command right after reset release, sourcing the cleared acc.
        run_op(0, 4'd0, 4'd6, 4'd14, 1, 1, 1, 0, 0, 0);
        run_op(0, 4'd0, 4'd3, 4'd2,  0, 0, 1, 2, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
